payload_extractor: RTL and testbench

PAYLOAD_EXTRACTOR -- requirements
Module: payload_extractor

---
 rtl/payload_pkg.sv | 15 +
 rtl/payload_extractor_sync_fifo.sv | 47 ++++
 rtl/payload_extractor.sv | 166 ++++++++++++++++
 tb/tb_payload_extractor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/payload_pkg.sv
// Shared definitions for the payload extractor: FSM states and the
// type/length field boundaries.
package payload_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEN_PAYLOAD,
    TYPE_PAYLOAD,
    SKIP
  } state_t;

  localparam int          MAX_LEN_DEFAULT = 1500;
  localparam logic [15:0] TYPE_MIN        = 16'h0600;

endpackage

// File: rtl/payload_extractor_sync_fifo.sv
// Synchronous FIFO with combinational read of the head entry and an
// occupancy count. The caller never writes when full without a same-edge pop.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_wrEn,
  input  logic [WIDTH-1:0]         i_wrData,
  input  logic                     i_rdEn,
  output logic [WIDTH-1:0]         o_rdData,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_rdEn) r_rdPtr <= r_rdPtr + 1'b1;
      case ({i_wrEn, i_rdEn})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_wrEn) r_mem[r_wrPtr] <= i_wrData;
  end

  assign o_rdData = (r_count == '0) ? '0 : r_mem[r_rdPtr];
  assign o_count  = r_count;

endmodule

// File: rtl/payload_extractor.sv
// Extracts the payload of a received frame after the type/length field and
// streams it out through a FIFO, flagging good and bad frames.
module payload_extractor
  import payload_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_LEN    = MAX_LEN_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        control,
  input  logic        type_length_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] length,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [3:0]  good_frame_count
);

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [15:0] MAX_LEN16  = 16'(MAX_LEN);

  state_t        r_state;
  logic [7:0]    r_prevByte;
  logic [15:0]   r_byteCount;
  logic [7:0]    r_stage;
  logic          r_stageValid;
  logic          r_errSeen;

  logic [15:0]   w_field;
  logic          w_tlv;
  logic          w_push;
  logic [7:0]    w_pushData;
  logic          w_pushLast;
  logic          w_pushOk;
  logic          w_wrEn;
  logic          w_pop;
  logic [8:0]    w_rdData;
  logic [CW-1:0] w_fifoCount;

  assign w_field  = {r_prevByte, data};
  assign w_tlv    = type_length_valid & control;
  assign w_pop    = out_valid & out_ready;
  assign w_pushOk = (w_fifoCount != FULL_COUNT) | w_pop;
  assign w_wrEn   = w_push & w_pushOk;

  // Length frames push the live byte; type frames push the staged byte so the
  // final one can be tagged last when control falls.
  always_comb begin
    w_push     = 1'b0;
    w_pushData = data;
    w_pushLast = 1'b0;
    case (r_state)
      LEN_PAYLOAD: begin
        w_push     = control;
        w_pushLast = (r_byteCount == length - 16'd1);
      end
      TYPE_PAYLOAD: begin
        w_push     = r_stageValid;
        w_pushData = r_stage;
        w_pushLast = ~control;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_prevByte       <= '0;
      r_byteCount      <= '0;
      r_stage          <= '0;
      r_stageValid     <= 1'b0;
      r_errSeen        <= 1'b0;
      length           <= '0;
      frame_ok         <= 1'b0;
      frame_err        <= 1'b0;
      good_frame_count <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (control) r_prevByte <= data;
      case (r_state)
        IDLE: begin
          if (w_tlv) begin
            length       <= w_field;
            r_byteCount  <= '0;
            r_stageValid <= 1'b0;
            r_errSeen    <= 1'b0;
            if (w_field != 16'd0 && w_field <= MAX_LEN16) begin
              r_state <= LEN_PAYLOAD;
            end else if (w_field >= TYPE_MIN) begin
              r_state <= TYPE_PAYLOAD;
            end else begin
              r_state   <= SKIP;
              frame_err <= 1'b1;
              r_errSeen <= 1'b1;
            end
          end
        end
        LEN_PAYLOAD: begin
          if (!control) begin
            frame_err <= 1'b1;
            r_state   <= IDLE;
          end else if (!w_pushOk) begin
            frame_err <= 1'b1;
            r_errSeen <= 1'b1;
            r_state   <= SKIP;
          end else begin
            r_byteCount <= r_byteCount + 16'd1;
            if (w_pushLast) r_state <= SKIP;
          end
        end
        TYPE_PAYLOAD: begin
          if (w_push && !w_pushOk) begin
            frame_err    <= 1'b1;
            r_errSeen    <= 1'b1;
            r_stageValid <= 1'b0;
            r_state      <= control ? SKIP : IDLE;
          end else if (!control) begin
            frame_ok         <= 1'b1;
            good_frame_count <= good_frame_count + 4'd1;
            r_stageValid     <= 1'b0;
            r_state          <= IDLE;
          end else begin
            r_stage      <= data;
            r_stageValid <= 1'b1;
          end
        end
        SKIP: begin
          if (!control) begin
            r_state <= IDLE;
            if (!r_errSeen) begin
              frame_ok         <= 1'b1;
              good_frame_count <= good_frame_count + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_wrEn   (w_wrEn),
    .i_wrData ({w_pushLast, w_pushData}),
    .i_rdEn   (w_pop),
    .o_rdData (w_rdData),
    .o_count  (w_fifoCount)
  );

  assign out_valid = (w_fifoCount != '0);
  assign out_last  = w_rdData[8];
  assign out_data  = w_rdData[7:0];

endmodule

// File: tb/tb_payload_extractor.sv
// Scoreboard bench for payload_extractor: frames are described as a field plus
// payload bytes; a frame-level model predicts outputs and status pulses.
module tb_payload_extractor;

  localparam int FIFO_DEPTH = 16;
  localparam int MAX_LEN    = 1500;

  typedef struct packed {
    logic       isOk;
    logic [3:0] cnt;
  } status_t;

  logic        clock;
  logic        reset;
  logic [7:0]  data;
  logic        control;
  logic        typeLengthValid;
  logic [7:0]  outData;
  logic        outLast;
  logic        outValid;
  logic        outReady;
  logic [15:0] length;
  logic        frameOk;
  logic        frameErr;
  logic [3:0]  goodFrameCount;

  logic [8:0]  expQ[$];
  status_t     statQ[$];
  logic [7:0]  txBytes[$];
  int          modelCount;
  int          readyMode;
  int          checks;
  int          errors;

  logic        heldValid;
  logic [8:0]  heldWord;
  logic [8:0]  expWord;
  status_t     expStat;

  payload_extractor #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .data              (data),
    .control           (control),
    .type_length_valid (typeLengthValid),
    .out_data          (outData),
    .out_last          (outLast),
    .out_valid         (outValid),
    .out_ready         (outReady),
    .length            (length),
    .frame_ok          (frameOk),
    .frame_err         (frameErr),
    .good_frame_count  (goodFrameCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Consumer side: 0 = stalled, 1 = always ready, 2 = random backpressure.
  always @(posedge clock) begin
    #1;
    case (readyMode)
      0:       outReady = 1'b0;
      1:       outReady = 1'b1;
      default: outReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every handshake and every status pulse against the queues.
  always @(negedge clock) begin
    if (reset) begin
      heldValid = 1'b0;
    end else begin
      if (heldValid) begin
        checks++;
        if (!outValid || {outLast, outData} !== heldWord) begin
          errors++;
          $display("[TB] FAIL hold_stable got valid=%0b word=%h required valid=1 word=%h",
                   outValid, {outLast, outData}, heldWord);
        end
      end
      heldValid = outValid && !outReady;
      heldWord  = {outLast, outData};
      if (outValid && outReady) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output got last=%0b data=%h required no output",
                   outLast, outData);
        end else begin
          expWord = expQ.pop_front();
          if ({outLast, outData} !== expWord) begin
            errors++;
            $display("[TB] FAIL payload_word got last=%0b data=%h required last=%0b data=%h",
                     outLast, outData, expWord[8], expWord[7:0]);
          end
        end
      end
      if (frameOk || frameErr) begin
        checks++;
        if (frameOk && frameErr) begin
          errors++;
          $display("[TB] FAIL status_both got ok=1 err=1 required one pulse");
        end else if (statQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_status got ok=%0b err=%0b required none", frameOk, frameErr);
        end else begin
          expStat = statQ.pop_front();
          if (frameOk !== expStat.isOk || goodFrameCount !== expStat.cnt) begin
            errors++;
            $display("[TB] FAIL status_pulse got ok=%0b count=%0d required ok=%0b count=%0d",
                     frameOk, goodFrameCount, expStat.isOk, expStat.cnt);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic pushStatus(input bit ok);
    status_t s;
    if (ok) modelCount = (modelCount + 1) % 16;
    s.isOk = ok;
    s.cnt  = 4'(modelCount);
    statQ.push_back(s);
  endtask

  // Frame-level reference: what a frame with this field and these bytes yields.
  task automatic modelFrame(input logic [15:0] field);
    int n;
    int f;
    n = txBytes.size();
    f = int'(field);
    if (f >= 1 && f <= MAX_LEN) begin
      if (n < f) begin
        for (int i = 0; i < n; i++) expQ.push_back({1'b0, txBytes[i]});
        pushStatus(1'b0);
      end else begin
        for (int i = 0; i < f; i++) expQ.push_back({1'(i == f - 1), txBytes[i]});
        pushStatus(1'b1);
      end
    end else if (f >= 16'h0600) begin
      for (int i = 0; i < n; i++) expQ.push_back({1'(i == n - 1), txBytes[i]});
      pushStatus(1'b1);
    end else begin
      pushStatus(1'b0);
    end
  endtask

  task automatic driveCycle(input logic [7:0] d, input logic c, input logic t);
    data            = d;
    control         = c;
    typeLengthValid = t;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] field, input bit spurious,
                               input bit checkLatency, input bit useModel);
    int spurIdx;
    spurIdx = -1;
    if (spurious && txBytes.size() > 1) spurIdx = int'($urandom_range(1, txBytes.size() - 1));
    if (useModel) modelFrame(field);
    for (int i = 0; i < 4; i++) driveCycle(8'($urandom), 1'b1, 1'b0);
    driveCycle(field[15:8], 1'b1, 1'b0);
    driveCycle(field[7:0], 1'b1, 1'b1);
    for (int i = 0; i < txBytes.size(); i++) begin
      driveCycle(txBytes[i], 1'b1, 1'(i == spurIdx));
      if (checkLatency && i == 0) begin
        checkOutput("latency_valid", 32'(outValid), 32'd1);
        checkOutput("latency_data", 32'(outData), 32'(txBytes[0]));
      end
    end
    for (int i = 0; i < 3; i++) driveCycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((expQ.size() != 0 || statQ.size() != 0) && budget < 300) begin
      @(posedge clock);
      #1;
      budget++;
    end
    checks++;
    if (expQ.size() != 0 || statQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got pending outputs=%0d status=%0d required 0",
               expQ.size(), statQ.size());
      expQ.delete();
      statQ.delete();
    end
  endtask

  task automatic doReset();
    reset           = 1'b1;
    control         = 1'b0;
    data            = 8'h00;
    typeLengthValid = 1'b0;
    expQ.delete();
    statQ.delete();
    modelCount = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    modelCount      = 0;
    readyMode       = 1;
    outReady        = 1'b1;
    heldValid       = 1'b0;
    reset           = 1'b1;
    control         = 1'b0;
    data            = 8'h00;
    typeLengthValid = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_out_data", 32'(outData), 32'd0);
    checkOutput("rst_out_last", 32'(outLast), 32'd0);
    checkOutput("rst_length", 32'(length), 32'd0);
    checkOutput("rst_frame_ok", 32'(frameOk), 32'd0);
    checkOutput("rst_frame_err", 32'(frameErr), 32'd0);
    checkOutput("rst_good_count", 32'(goodFrameCount), 32'd0);
    doReset();

    // Length frame: 4 payload bytes, padding and FCS dropped.
    txBytes.delete();
    for (int i = 1; i <= 4; i++) txBytes.push_back(8'(i));
    for (int i = 0; i < 46; i++) txBytes.push_back(8'($urandom));
    applyStimulus(16'h0004, 1'b0, 1'b1, 1'b1);
    drain();
    checkOutput("length_reg", 32'(length), 32'h0004);
    checkOutput("count_after_len", 32'(goodFrameCount), 32'd1);

    // Type frame with a stray type_length_valid mid-payload.
    txBytes.delete();
    for (int i = 0; i < 10; i++) txBytes.push_back(8'(8'hA0 + i));
    applyStimulus(16'h0800, 1'b1, 1'b0, 1'b1);
    drain();
    checkOutput("count_after_type", 32'(goodFrameCount), 32'd2);

    // Illegal fields: between MAX_LEN and TYPE_MIN, and zero.
    foreach (txBytes[i]) txBytes[i] = 8'($urandom);
    applyStimulus(16'h05FF, 1'b0, 1'b0, 1'b1);
    drain();
    applyStimulus(16'(MAX_LEN + 1), 1'b0, 1'b0, 1'b1);
    drain();
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
    drain();
    checkOutput("count_after_illegal", 32'(goodFrameCount), 32'd2);

    // Runt length frame.
    txBytes.delete();
    for (int i = 0; i < 10; i++) txBytes.push_back(8'($urandom));
    applyStimulus(16'h0030, 1'b0, 1'b0, 1'b1);
    drain();

    // Overflow: stalled consumer, 20-byte type frame keeps the first 16 bytes.
    readyMode = 0;
    @(posedge clock);
    #1;
    txBytes.delete();
    for (int i = 0; i < 20; i++) txBytes.push_back(8'($urandom));
    for (int i = 0; i < FIFO_DEPTH; i++) expQ.push_back({1'b0, txBytes[i]});
    pushStatus(1'b0);
    applyStimulus(16'h0900, 1'b0, 1'b0, 1'b0);
    checkOutput("overflow_valid", 32'(outValid), 32'd1);
    readyMode = 1;
    drain();

    // Boundaries: MAX_LEN length frame and TYPE_MIN type frame.
    txBytes.delete();
    for (int i = 0; i < MAX_LEN + 4; i++) txBytes.push_back(8'($urandom));
    applyStimulus(16'(MAX_LEN), 1'b0, 1'b0, 1'b1);
    drain();
    txBytes.delete();
    for (int i = 0; i < 5; i++) txBytes.push_back(8'($urandom));
    applyStimulus(16'h0600, 1'b0, 1'b0, 1'b1);
    drain();

    // Random frames under random backpressure; payload never exceeds the FIFO.
    readyMode = 2;
    for (int f = 0; f < 40; f++) begin
      logic [15:0] field;
      int          n;
      int          kind;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          field = 16'($urandom_range(1, 16));
          n     = int'(field) + int'($urandom_range(0, 6));
        end
        1: begin
          field = 16'($urandom_range(2, 16));
          n     = int'($urandom_range(1, int'(field) - 1));
        end
        2: begin
          field = 16'(16'h0600 + $urandom_range(0, 16'h9FFF));
          n     = int'($urandom_range(1, 16));
        end
        default: begin
          field = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(MAX_LEN + 1, 16'h05FF));
          n     = int'($urandom_range(0, 10));
        end
      endcase
      txBytes.delete();
      for (int i = 0; i < n; i++) txBytes.push_back(8'($urandom));
      applyStimulus(field, ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
      drain();
    end

    // Counter wrap: 17 good frames from reset.
    readyMode = 1;
    doReset();
    for (int f = 0; f < 17; f++) begin
      txBytes.delete();
      txBytes.push_back(8'($urandom));
      txBytes.push_back(8'($urandom));
      applyStimulus(16'h0800, 1'b0, 1'b0, 1'b1);
      drain();
    end
    checkOutput("wrap_count", 32'(goodFrameCount), 32'd1);

    // Reset in the middle of a length payload.
    readyMode = 0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) driveCycle(8'($urandom), 1'b1, 1'b0);
    driveCycle(8'h00, 1'b1, 1'b0);
    driveCycle(8'h20, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) driveCycle(8'($urandom), 1'b1, 1'b0);
    checkOutput("pre_reset_valid", 32'(outValid), 32'd1);
    #2;
    reset = 1'b1;
    expQ.delete();
    statQ.delete();
    modelCount = 0;
    #1;
    checkOutput("reset_mid_valid", 32'(outValid), 32'd0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    readyMode = 1;
    for (int i = 0; i < 10; i++) driveCycle(8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) driveCycle(8'h00, 1'b0, 1'b0);
    checkOutput("post_reset_valid", 32'(outValid), 32'd0);
    checkOutput("post_reset_count", 32'(goodFrameCount), 32'd0);
    checkOutput("post_reset_length", 32'(length), 32'd0);

    // A normal frame still works afterwards.
    readyMode = 2;
    txBytes.delete();
    for (int i = 0; i < 7; i++) txBytes.push_back(8'($urandom));
    applyStimulus(16'h0003, 1'b0, 1'b0, 1'b1);
    drain();
    checkOutput("final_count", 32'(goodFrameCount), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
